// File: rtl/csa_accum_pkg.sv
// Shared types and helpers for the CSA accumulation controller.
package csa_accum_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      RESOLVE,
      DONE
   } accumState;

   localparam int EXT_MAX_W = 64;

   // Widens an operand of the given width to EXT_MAX_W bits; callers cast down to their accumulator width.
   function automatic logic [EXT_MAX_W-1:0] extendOperand(input logic [EXT_MAX_W-1:0] x,
                                                          input int width,
                                                          input bit isSigned);
      logic [EXT_MAX_W-1:0] r;
      r = x;
      for (int i = 0; i < EXT_MAX_W; i++) begin
         if (i >= width) begin
            r[i] = isSigned ? x[width-1] : 1'b0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/csa_ha.sv
// 2:1 compressor (half adder) cell used by the iterative carry-resolve row.
module csa_ha (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

// File: rtl/csa_row.sv
// ACC_W-wide row of 3:2 compressors; carry comes out already shifted left with the MSB dropped.
module csa_row #(
   parameter int ACC_W = 20
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   input  logic [ACC_W-1:0] c,
   output logic [ACC_W-1:0] sum,
   output logic [ACC_W-1:0] carry
);

   logic [ACC_W-2:0] majority;

   assign sum = a ^ b ^ c;

   // The top bit's majority would be shifted out, so it is never formed.
   assign majority = (a[ACC_W-2:0] & b[ACC_W-2:0])
                   | (a[ACC_W-2:0] & c[ACC_W-2:0])
                   | (b[ACC_W-2:0] & c[ACC_W-2:0]);

   assign carry = {majority, 1'b0};

endmodule

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: CSA reduction of a packet into sum/carry, then carry resolution.
// Define CSA_ACCUM_FAST_RESOLVE_EN for a single-cycle carry-propagate resolve.
module csa_accum_ctrl
   import csa_accum_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int CNT_W  = 4,
   parameter int SIGNED = 0,
   localparam int ACC_W = WIDTH + CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count
);

   accumState        state;
   accumState        stateNext;
   logic [ACC_W-1:0] sumReg;
   logic [ACC_W-1:0] carryReg;
   logic [ACC_W-1:0] sumNext;
   logic [ACC_W-1:0] carryNext;
   logic [ACC_W-1:0] opExt;
   logic [ACC_W-1:0] rowSum;
   logic [ACC_W-1:0] rowCarry;
   logic [CNT_W-1:0] cntReg;
   logic [CNT_W-1:0] cntNext;
   logic [CNT_W-1:0] cntInc;
   logic             accept;
   logic             lastBeat;

   assign in_ready = ((state == IDLE) || (state == ACCUM)) && !rst;
   assign accept   = in_valid && in_ready;
   assign cntInc   = cntReg + CNT_W'(1);
   assign lastBeat = in_last || (cntInc == '1);
   assign opExt    = ACC_W'(extendOperand(64'(in_data), WIDTH, SIGNED != 0));

   csa_row #(
      .ACC_W(ACC_W)
   ) accumRow (
      .a    (sumReg),
      .b    (carryReg),
      .c    (opExt),
      .sum  (rowSum),
      .carry(rowCarry)
   );

`ifdef CSA_ACCUM_FAST_RESOLVE_EN
   logic [ACC_W-1:0] resolveSum;

   assign resolveSum = sumReg + carryReg;
`else
   logic [ACC_W-1:0] haSum;
   logic [ACC_W-2:0] haCarry;

   for (genvar i = 0; i < ACC_W - 1; i++) begin : g_ha
      csa_ha ha (
         .a    (sumReg[i]),
         .b    (carryReg[i]),
         .sum  (haSum[i]),
         .carry(haCarry[i])
      );
   end

   // The MSB's carry would be dropped by the shift, so only its sum bit is needed.
   assign haSum[ACC_W-1] = sumReg[ACC_W-1] ^ carryReg[ACC_W-1];
`endif

   always_comb begin
      stateNext = state;
      sumNext   = sumReg;
      carryNext = carryReg;
      cntNext   = cntReg;
      case (state)
         IDLE, ACCUM: begin
            if (accept) begin
               sumNext   = rowSum;
               carryNext = rowCarry;
               cntNext   = cntInc;
               stateNext = lastBeat ? RESOLVE : ACCUM;
            end
         end
         RESOLVE: begin
`ifdef CSA_ACCUM_FAST_RESOLVE_EN
            sumNext   = resolveSum;
            carryNext = '0;
            stateNext = DONE;
`else
            if (carryReg == '0) begin
               stateNext = DONE;
            end else begin
               sumNext   = haSum;
               carryNext = {haCarry, 1'b0};
            end
`endif
         end
         DONE: begin
            if (out_ready) begin
               stateNext = IDLE;
               sumNext   = '0;
               carryNext = '0;
               cntNext   = '0;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sumReg   <= '0;
         carryReg <= '0;
         cntReg   <= '0;
      end else begin
         state    <= stateNext;
         sumReg   <= sumNext;
         carryReg <= carryNext;
         cntReg   <= cntNext;
      end
   end

   assign out_valid = (state == DONE);
   assign out_sum   = (state == DONE) ? sumReg : '0;
   assign out_count = (state == DONE) ? cntReg : '0;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Self-checking bench for csa_accum_ctrl: directed vector table, corner sequences, and random packets.
module tb_csa_accum_ctrl;

`ifdef CSA_ACCUM_FAST_RESOLVE_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       inValid;
   logic [7:0] inData;
   logic       inLast;
   logic       outReady;
   int         sel;

   logic        readyA, validA, readyB, validB, readyC, validC;
   logic [11:0] sumA, sumB;
   logic [9:0]  sumC;
   logic [3:0]  countA, countB;
   logic [1:0]  countC;

   logic        readyM, validM;
   logic [11:0] sumM;
   logic [3:0]  countM;

   logic [7:0]  pktOps [16];
   int          compared   = 0;
   int          mismatched = 0;

   always #5 clk = ~clk;

   csa_accum_ctrl #(.WIDTH(8), .CNT_W(4), .SIGNED(0)) dutA (
      .clk(clk), .rst(rst), .in_valid(inValid && sel == 0), .in_ready(readyA),
      .in_data(inData), .in_last(inLast), .out_valid(validA),
      .out_ready(outReady && sel == 0), .out_sum(sumA), .out_count(countA));

   csa_accum_ctrl #(.WIDTH(8), .CNT_W(4), .SIGNED(1)) dutB (
      .clk(clk), .rst(rst), .in_valid(inValid && sel == 1), .in_ready(readyB),
      .in_data(inData), .in_last(inLast), .out_valid(validB),
      .out_ready(outReady && sel == 1), .out_sum(sumB), .out_count(countB));

   csa_accum_ctrl #(.WIDTH(8), .CNT_W(2), .SIGNED(0)) dutC (
      .clk(clk), .rst(rst), .in_valid(inValid && sel == 2), .in_ready(readyC),
      .in_data(inData), .in_last(inLast), .out_valid(validC),
      .out_ready(outReady && sel == 2), .out_sum(sumC), .out_count(countC));

   // Route the selected instance onto one set of observation signals.
   always_comb begin
      readyM = readyC;
      validM = validC;
      sumM   = {2'b00, sumC};
      countM = {2'b00, countC};
      if (sel == 0) begin
         readyM = readyA; validM = validA; sumM = sumA; countM = countA;
      end else if (sel == 1) begin
         readyM = readyB; validM = validB; sumM = sumB; countM = countB;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drives pktOps[0..n-1]; returns #1 after the clock edge that accepted the final beat.
   task automatic sendBeats(input int n, input bit useLast, input int gapMax, output bit ok);
      int guard;
      int gap;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         gap = (gapMax > 0) ? $urandom_range(gapMax, 0) : 0;
         repeat (gap) begin
            @(posedge clk); #1;
         end
         inValid = 1'b1;
         inData  = pktOps[i];
         inLast  = useLast && (i == n - 1);
         guard   = 0;
         while (!readyM && guard < 40) begin
            @(posedge clk); #1;
            guard++;
         end
         if (!readyM) begin
            checkOutput("beat accept timeout", 0, 1);
            inValid = 1'b0;
            ok = 1'b0;
            return;
         end
         @(posedge clk); #1;
         inValid = 1'b0;
         inLast  = 1'b0;
      end
   endtask

   task automatic applyStimulus(input int inst, input int n, input bit useLast, input int gapMax,
                                input int hold, input logic [11:0] expSum, input logic [3:0] expCount,
                                output int gotLat);
      bit ok;
      sel    = inst;
      gotLat = -1;
      sendBeats(n, useLast, gapMax, ok);
      if (!ok) return;
      checkOutput("in_ready low after last beat", readyM, 0);
      gotLat = 1;
      while (!validM && gotLat < 40) begin
         @(posedge clk); #1;
         gotLat++;
      end
      if (!validM) begin
         checkOutput("result timeout", 0, 1);
         return;
      end
      checkOutput("out_sum", sumM, expSum);
      checkOutput("out_count", countM, expCount);
      repeat (hold) begin
         @(posedge clk); #1;
         checkOutput("held out_valid", validM, 1);
         checkOutput("held out_sum", sumM, expSum);
         checkOutput("held out_count", countM, expCount);
         checkOutput("in_ready low in DONE", readyM, 0);
      end
      outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
      checkOutput("out_valid drops after handshake", validM, 0);
      checkOutput("in_ready after handshake", readyM, 1);
   endtask

   typedef struct packed {
      logic [1:0]      inst;
      logic [4:0]      n;
      logic            useLast;
      logic [3:0][7:0] ops;
      logic [11:0]     expSum;
      logic [3:0]      expCount;
      logic [4:0]      expLat;
   } vecT;

   vecT vecs [5];

   initial begin
      int  lat;
      int  inst;
      int  n;
      int  acc;
      bit  useLast;
      bit  ok;

      vecs[0] = '{inst: 2'd0, n: 5'd3, useLast: 1'b1, ops: {8'd0, 8'd9, 8'd7, 8'd5},
                  expSum: 12'd21, expCount: 4'd3, expLat: FAST ? 5'd2 : 5'd3};
      vecs[1] = '{inst: 2'd0, n: 5'd1, useLast: 1'b1, ops: {8'd0, 8'd0, 8'd0, 8'hFF},
                  expSum: 12'd255, expCount: 4'd1, expLat: 5'd2};
      vecs[2] = '{inst: 2'd0, n: 5'd4, useLast: 1'b1, ops: {8'hFF, 8'hFF, 8'hFF, 8'hFF},
                  expSum: 12'd1020, expCount: 4'd4, expLat: FAST ? 5'd2 : 5'd4};
      vecs[3] = '{inst: 2'd1, n: 5'd2, useLast: 1'b1, ops: {8'd0, 8'd0, 8'h02, 8'hFD},
                  expSum: 12'hFFF, expCount: 4'd2, expLat: 5'd2};
      vecs[4] = '{inst: 2'd2, n: 5'd3, useLast: 1'b0, ops: {8'd0, 8'd3, 8'd2, 8'd1},
                  expSum: 12'd6, expCount: 4'd3, expLat: FAST ? 5'd2 : 5'd3};

      sel = 0; rst = 1'b1; inValid = 1'b0; inData = '0; inLast = 1'b0; outReady = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset out_valid", validM, 0);
      checkOutput("reset out_sum", sumM, 0);
      checkOutput("reset out_count", countM, 0);
      checkOutput("in_ready low in reset", readyM, 0);
      rst = 1'b0;
      #1;
      checkOutput("in_ready after reset", readyM, 1);

      $display("[TB] directed vectors");
      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < 4; i++) pktOps[i] = vecs[v].ops[i];
         applyStimulus(int'(vecs[v].inst), int'(vecs[v].n), vecs[v].useLast, 0, (v == 0) ? 5 : 1,
                       vecs[v].expSum, vecs[v].expCount, lat);
         checkOutput($sformatf("vec%0d latency", v), lat, 32'(vecs[v].expLat));
      end

      $display("[TB] reset during RESOLVE");
      sel = 0;
      for (int i = 0; i < 4; i++) pktOps[i] = 8'hFF;
      sendBeats(4, 1'b1, 0, ok);
      rst = 1'b1;
      #1;
      checkOutput("in_ready low with rst in RESOLVE", readyM, 0);
      @(posedge clk); #1;
      checkOutput("abort out_valid", validM, 0);
      checkOutput("abort out_sum", sumM, 0);
      checkOutput("abort out_count", countM, 0);
      rst = 1'b0;
      #1;
      pktOps[0] = 8'd1;
      pktOps[1] = 8'd2;
      applyStimulus(0, 2, 1'b1, 0, 0, 12'd3, 4'd2, lat);
      checkOutput("post-abort latency", lat, 2);

      $display("[TB] random packets");
      for (int p = 0; p < 40; p++) begin
         inst    = int'($urandom_range(1, 0));
         n       = int'($urandom_range(15, 1));
         useLast = (n < 15) ? 1'b1 : 1'($urandom_range(1, 0));
         acc     = 0;
         for (int i = 0; i < n; i++) begin
            pktOps[i] = 8'($urandom_range(255, 0));
            acc += (inst == 1) ? int'($signed(pktOps[i])) : int'(pktOps[i]);
         end
         applyStimulus(inst, n, useLast, 2, int'($urandom_range(3, 0)), 12'(acc), 4'(n), lat);
         if (FAST) checkOutput("random latency", lat, 2);
         else      checkOutput("random latency in range", 32'(lat >= 2 && lat <= 14), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
